reg_file_sequencer: RTL
=======================

# reg_file_sequencer

Bus-master sequencer that drives the write port and read port A of `reg_file` (16 x 8-bit, synchronous write, combinational read). On command it either loads a run of registers from a valid/ready byte stream or dumps a run of registers onto a valid/ready output stream. It sits between the debug/boot loader path and `reg_file`, and is muxed onto the register-file ports only while `busy` is high.

## Interface
- `NREGS`, 16, number of registers; the address range wraps modulo `NREGS`.
- `AW`, 4, register address width (log2 `NREGS`).
- `W`, 8, data width.

- `clk` input 1 — single clock, all state changes on rising edge.
- `reset` input 1 — synchronous, active-high.
- `start_load` input 1 — begin a load run; sampled in IDLE only.
- `start_dump` input 1 — begin a dump run; sampled in IDLE only.
- `base` input AW — first register address; latched at start.
- `len` input AW+1 — number of registers, 0..16; latched at start.
- `in_data` input W — load stream byte.
- `in_valid` input 1 — load stream valid.
- `in_ready` output 1 — load stream ready.
- `out_data` output W — dump stream byte.
- `out_valid` output 1 — dump stream valid.
- `out_ready` input 1 — dump stream ready.
- `busy` output 1 — high in LOAD or DUMP.
- `done` output 1 — one-cycle pulse at the end of a run.
- `RegWrite` output 1 — reg_file write enable.
- `write_register` output AW — reg_file write address.
- `data_in` output W — reg_file write data.
- `raddrA` output AW — reg_file read address A.
- `data_outA` input W — reg_file read data A (combinational from `raddrA`).

## Operation
- Registered state: FSM {IDLE, LOAD, DUMP, DONE}, address pointer `ptr` (AW bits), remaining count `rem` (AW+1 bits).
- IDLE:
  - `start_load`=1 → latch `ptr`=`base` and `rem`=`len`; go to LOAD if `len`≠0, else DONE.
  - `start_dump`=1 (with `start_load`=0) → same latching; go to DUMP if `len`≠0, else DONE.
  - Both starts high together → load wins.
- LOAD:
  - `in_ready`=1.
  - Beat = `in_valid`&`in_ready`.
  - On a beat: `RegWrite`=1, `write_register`=`ptr`, `data_in`=`in_data` (combinational, same cycle); at the edge `ptr`←`ptr`+1 mod 16 and `rem`←`rem`−1.
  - Beat with `rem`=1 → DONE.
  - No beat → `RegWrite`=0.
- DUMP:
  - `raddrA`=`ptr`, `out_data`=`data_outA`, `out_valid`=1.
  - On `out_valid`&`out_ready`: `ptr`++ mod 16 and `rem`−−.
  - Accepted beat with `rem`=1 → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Starts asserted outside IDLE are ignored; they are not queued.
- Address wrap: `base`=14, `len`=4 touches registers 14, 15, 0, 1.
- Outside LOAD: `RegWrite`, `write_register` and `data_in` are 0.
- Outside DUMP: `raddrA` and `out_data` are 0, `out_valid`=0.
- `in_ready`=0 outside LOAD.

## Timing
- Reset values: state IDLE, `ptr`=0, `rem`=0; all outputs 0.
- Reset mid-run:
  - Abort at the edge; no `done` pulse.
  - `RegWrite` is forced 0 in any cycle where `reset`=1, so no write occurs in the reset cycle.
- Start to first beat: 1 cycle. `start_*` at edge N puts the FSM in LOAD/DUMP from cycle N+1.
- Throughput: one register per cycle with continuous valid/ready.
- A run of `len`=L with no stalls:
  - `busy` is high for L cycles.
  - `done` is high in the cycle after the last beat.
  - The block is back in IDLE (accepts a new start) the cycle after that.
- `len`=0: no bus activity, `busy` stays 0, `done` pulses the cycle after the start.
- Write visibility: a write beat in cycle N is readable on `data_outA` from cycle N+1.
- Dump stall (`out_ready`=0): `out_data` and `raddrA` hold stable, and `out_valid` stays high until the beat is accepted.
- `len` > 16 is not representable; `len`=16 covers every register exactly once.

## Test plan
- Load base=0, len=16, bytes 0x10..0x1F with `in_valid` held high:
  - 16 consecutive `RegWrite` cycles, addresses 0..15.
  - `done` pulses at cycle 17 after entering LOAD.
  - Direct reads show reg[k]=0x10+k.
- Load base=14, len=4, data 0xFF, 0xC8, 0x9B, 0x02 with `in_valid` toggling 1,0,1,0,...:
  - reg14=0xFF, reg15=0xC8, reg0=0x9B, reg1=0x02.
  - No `RegWrite` in the `in_valid`=0 cycles.
- Dump base=14, len=4 after the previous test, `out_ready` low for 3 cycles on beat 2:
  - Output sequence 0xFF, 0xC8, 0x9B, 0x02.
  - `out_data`=0xC8 and `raddrA`=15 held during the stall.
- `start_load` and `start_dump` high together with len=1 → load run (`in_ready`=1, `out_valid`=0).
- `start_dump` with len=0 → `done` the next cycle, `busy` never high, `raddrA` stays 0.
- `reset` asserted mid-load after 2 of 5 beats:
  - Only 2 registers written, no `done`.
  - All outputs 0 the cycle after reset.
  - A new load of len=1 works immediately after reset deasserts.

Source files
------------

// File: rtl/reg_file_sequencer.sv
// Load/dump sequencer for a 16 x 8 register file.
// Streams a wrapping run of registers in from or out to a valid/ready port.
module reg_file_sequencer #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          start_dump,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          RegWrite,
  output logic [AW-1:0] write_register,
  output logic [W-1:0]  data_in,
  output logic [AW-1:0] raddrA,
  input  logic [W-1:0]  data_outA
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;

  logic in_load;
  logic in_dump;
  logic wbeat;
  logic rbeat;
  logic last;

  assign in_load = (state == LOAD);
  assign in_dump = (state == DUMP);
  // reset gates the write strobe so an aborted run never commits a byte
  assign wbeat   = in_load && in_valid && !reset;
  assign rbeat   = in_dump && out_ready;
  assign last    = (rem == (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_load || start_dump) begin
            ptr <= base;
            rem <= len;
            if (len == '0)
              state <= DONE;
            else if (start_load)
              state <= LOAD;
            else
              state <= DUMP;
          end
        end
        LOAD: begin
          if (in_valid) begin
            ptr <= ptr + AW'(1);
            rem <= rem - (AW+1)'(1);
            if (last)
              state <= DONE;
          end
        end
        DUMP: begin
          if (out_ready) begin
            ptr <= ptr + AW'(1);
            rem <= rem - (AW+1)'(1);
            if (last)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = in_load || in_dump;
  assign done           = (state == DONE);
  assign in_ready       = in_load;
  assign RegWrite       = wbeat;
  assign write_register = wbeat ? ptr : '0;
  assign data_in        = wbeat ? in_data : '0;
  assign out_valid      = in_dump;
  assign raddrA         = in_dump ? ptr : '0;
  assign out_data       = in_dump ? data_outA : '0;

  logic unused;
  assign unused = rbeat;

endmodule
